rotary_decoder: RTL and testbench

Converts raw quadrature signals from a detented rotary encoder into clean, single-cycle `cw` / `ccw` step pulses. It sits directly upstream of the 16-position memory-state counter, whose `cw`/`ccw` inputs it drives. Both pin inputs pass through a two-flop synchronizer and a per-bit debouncer. A detent-tracking FSM then emits exactly one pulse per completed detent.

---
 rtl/rotary_pkg.sv | 18 +
 rtl/rotary_decoder_debounce_bit.sv | 55 +++++
 rtl/rotary_decoder.sv | 135 +++++++++++++
 tb/tb_rotary_decoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// rotary_pkg: shared definitions for the rotary encoder decoder.
//   rot_state_e : detent-tracking FSM state encoding (3 bits)
//   REST_CODE   : {a, b} code seen while the encoder sits in a detent
package rotary_pkg;

  typedef enum logic [2:0] {
    ST_REST = 3'd0,
    ST_CW1  = 3'd1,
    ST_CW2  = 3'd2,
    ST_CW3  = 3'd3,
    ST_CCW1 = 3'd4,
    ST_CCW2 = 3'd5,
    ST_CCW3 = 3'd6
  } rot_state_e;

  localparam logic [1:0] REST_CODE = 2'b11;

endpackage

// File: rtl/rotary_decoder_debounce_bit.sv
// debounce_bit: two-flop synchronizer followed by a saturating-count debouncer.
//   clk  : system clock
//   rst  : synchronous active-high reset (sync flops and stable value reset to 1)
//   din  : asynchronous pin input
//   dout : debounced, synchronized value
// The stable value only follows the synchronized input after it has differed
// for DEBOUNCE_CYCLES consecutive cycles; any return to the stable value
// clears the count.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d   = {sync_q[0], din};
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      // Count reaching DEBOUNCE_CYCLES-1 while still differing means this is
      // the DEBOUNCE_CYCLES-th differing cycle, so accept the new value.
      // The count clears here, so it never wraps.
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/rotary_decoder.sv
// rotary_decoder: turns raw quadrature pins into single-cycle step pulses.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   rot_a   : encoder channel A (async pin, high at rest)
//   rot_b   : encoder channel B (async pin, high at rest)
//   cw      : one-cycle pulse per completed clockwise detent
//   ccw     : one-cycle pulse per completed counter-clockwise detent
//   seq_err : one-cycle pulse on an illegal two-bit code jump
// Each pin is synchronized and debounced, then a detent-tracking FSM walks
// the Gray sequence and pulses only when it returns to the rest code from
// the last quarter-step of a rotation. Reversals inside a detent walk back
// without pulsing. The FSM state is held in state_q.
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic rot_a,
  input  logic rot_b,
  output logic cw,
  output logic ccw,
  output logic seq_err
);

  logic       stable_a, stable_b;
  logic [1:0] code;

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk  (clk),
    .rst  (rst),
    .din  (rot_a),
    .dout (stable_a)
  );

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk  (clk),
    .rst  (rst),
    .din  (rot_b),
    .dout (stable_b)
  );

  assign code = {stable_a, stable_b};

  rot_state_e state_q, state_d;
  logic       cw_q, cw_d;
  logic       ccw_q, ccw_d;
  logic       err_q, err_d;

  always_comb begin
    state_d = state_q;
    cw_d    = 1'b0;
    ccw_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_REST: begin
        case (code)
          2'b01:   state_d = ST_CW1;
          2'b10:   state_d = ST_CCW1;
          2'b00:   err_d   = 1'b1;
          default: state_d = ST_REST;
        endcase
      end
      ST_CW1: begin
        case (code)
          2'b00:     state_d = ST_CW2;
          REST_CODE: state_d = ST_REST;
          2'b10:     begin err_d = 1'b1; state_d = ST_REST; end
          default:   state_d = ST_CW1;
        endcase
      end
      ST_CW2: begin
        case (code)
          2'b10:     state_d = ST_CW3;
          2'b01:     state_d = ST_CW1;
          REST_CODE: begin err_d = 1'b1; state_d = ST_REST; end
          default:   state_d = ST_CW2;
        endcase
      end
      ST_CW3: begin
        case (code)
          REST_CODE: begin cw_d = 1'b1; state_d = ST_REST; end
          2'b00:     state_d = ST_CW2;
          2'b01:     begin err_d = 1'b1; state_d = ST_REST; end
          default:   state_d = ST_CW3;
        endcase
      end
      ST_CCW1: begin
        case (code)
          2'b00:     state_d = ST_CCW2;
          REST_CODE: state_d = ST_REST;
          2'b01:     begin err_d = 1'b1; state_d = ST_REST; end
          default:   state_d = ST_CCW1;
        endcase
      end
      ST_CCW2: begin
        case (code)
          2'b01:     state_d = ST_CCW3;
          2'b10:     state_d = ST_CCW1;
          REST_CODE: begin err_d = 1'b1; state_d = ST_REST; end
          default:   state_d = ST_CCW2;
        endcase
      end
      ST_CCW3: begin
        case (code)
          REST_CODE: begin ccw_d = 1'b1; state_d = ST_REST; end
          2'b00:     state_d = ST_CCW2;
          2'b10:     begin err_d = 1'b1; state_d = ST_REST; end
          default:   state_d = ST_CCW3;
        endcase
      end
      default: state_d = ST_REST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REST;
      cw_q    <= 1'b0;
      ccw_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      ccw_q   <= ccw_d;
      err_q   <= err_d;
    end
  end

  assign cw      = cw_q;
  assign ccw     = ccw_q;
  assign seq_err = err_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// tb_rotary_decoder: directed testbench for rotary_decoder with DEBOUNCE_CYCLES=4.
// Inputs are driven on the falling edge; outputs are observed by a monitor
// 1 time unit after each rising edge and by the main sequence on falling edges.
module tb_rotary_decoder;
  import rotary_pkg::*;

  localparam int DB = 4;
  localparam int HOLD = 10;

  logic clk;
  logic rst;
  logic rot_a;
  logic rot_b;
  logic cw;
  logic ccw;
  logic seq_err;

  int checks;
  int errors;

  // Monitor state
  int cyc;
  int cw_cnt, ccw_cnt, err_cnt;
  int cw_cyc;
  int excl_viol;
  logic [2:0] err_state;

  rotary_decoder #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk     (clk),
    .rst     (rst),
    .rot_a   (rot_a),
    .rot_b   (rot_b),
    .cw      (cw),
    .ccw     (ccw),
    .seq_err (seq_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  initial begin
    cyc = 0; cw_cnt = 0; ccw_cnt = 0; err_cnt = 0;
    cw_cyc = -1; excl_viol = 0; err_state = 3'd7;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (cw) begin cw_cnt = cw_cnt + 1; cw_cyc = cyc; end
    if (ccw) ccw_cnt = ccw_cnt + 1;
    if (seq_err) begin err_cnt = err_cnt + 1; err_state = dut.state_q; end
    if ((cw && ccw) || (seq_err && (cw || ccw))) excl_viol = excl_viol + 1;
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_code(input logic [1:0] c, input int hold);
    rot_a = c[1];
    rot_b = c[0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic clear_counts();
    cw_cnt = 0; ccw_cnt = 0; err_cnt = 0; cw_cyc = -1; err_state = 3'd7;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rot_a = 1'b1;
    rot_b = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    int apply_cyc;
    int first_k;
    int glitch_fall;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rot_a = 1'b1;
    rot_b = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_cw", {31'd0, cw}, 32'd0);
    check_eq("rst_ccw", {31'd0, ccw}, 32'd0);
    check_eq("rst_err", {31'd0, seq_err}, 32'd0);
    check_eq("rst_state", {29'd0, dut.state_q}, {29'd0, ST_REST});
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: one clockwise detent. The pulse is registered 2+DB edges after the
    // first rising edge that samples the final 11.
    clear_counts();
    drive_code(2'b01, HOLD);
    drive_code(2'b00, HOLD);
    drive_code(2'b10, HOLD);
    apply_cyc = cyc;
    drive_code(2'b11, HOLD);
    check_eq("cw1_cw_cnt", cw_cnt, 32'd1);
    check_eq("cw1_ccw_cnt", ccw_cnt, 32'd0);
    check_eq("cw1_err_cnt", err_cnt, 32'd0);
    check_eq("cw1_latency", cw_cyc - (apply_cyc + 1), DB + 2);

    // 2: three counter-clockwise detents
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      drive_code(2'b10, HOLD);
      drive_code(2'b00, HOLD);
      drive_code(2'b01, HOLD);
      drive_code(2'b11, HOLD);
    end
    check_eq("ccw3_ccw_cnt", ccw_cnt, 32'd3);
    check_eq("ccw3_cw_cnt", cw_cnt, 32'd0);
    check_eq("ccw3_err_cnt", err_cnt, 32'd0);

    // 3: partial detent with reversal
    clear_counts();
    drive_code(2'b01, HOLD);
    drive_code(2'b00, HOLD);
    drive_code(2'b01, HOLD);
    drive_code(2'b11, HOLD);
    check_eq("rev_pulses", cw_cnt + ccw_cnt + err_cnt, 32'd0);
    check_eq("rev_state", {29'd0, dut.state_q}, {29'd0, ST_REST});

    // 4a: 3-cycle glitch on A must not reach the stable value
    clear_counts();
    glitch_fall = 0;
    rot_a = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 3) rot_a = 1'b1;
      if (dut.u_deb_a.dout == 1'b0) glitch_fall = 1;
    end
    check_eq("glitch_stable_a", glitch_fall, 32'd0);
    check_eq("glitch_pulses", cw_cnt + ccw_cnt + err_cnt, 32'd0);
    check_eq("glitch_state", {29'd0, dut.state_q}, {29'd0, ST_REST});

    // 4b: 5-cycle low on A is accepted. Counting falling edges from the
    // drive point, stable A is first seen low at k = DB+2.
    first_k = -1;
    rot_a = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 5) rot_a = 1'b1;
      if (first_k < 0 && dut.u_deb_a.dout == 1'b0) first_k = k;
    end
    check_eq("hold_stable_a_k", first_k, DB + 2);
    check_eq("hold_pulses", cw_cnt + ccw_cnt + err_cnt, 32'd0);
    check_eq("hold_state", {29'd0, dut.state_q}, {29'd0, ST_REST});

    // 5: illegal jump from CW1, then a full CCW detent
    clear_counts();
    drive_code(2'b01, HOLD);
    drive_code(2'b10, HOLD);
    check_eq("jump_err_cnt", err_cnt, 32'd1);
    check_eq("jump_err_state", {29'd0, err_state}, {29'd0, ST_REST});
    drive_code(2'b11, HOLD);
    drive_code(2'b10, HOLD);
    drive_code(2'b00, HOLD);
    drive_code(2'b01, HOLD);
    drive_code(2'b11, HOLD);
    check_eq("jump_ccw_cnt", ccw_cnt, 32'd1);
    check_eq("jump_cw_cnt", cw_cnt, 32'd0);
    check_eq("jump_err_total", err_cnt, 32'd1);

    // 6: reset while in CW3
    clear_counts();
    drive_code(2'b01, HOLD);
    drive_code(2'b00, HOLD);
    drive_code(2'b10, HOLD);
    check_eq("pre_rst_state", {29'd0, dut.state_q}, {29'd0, ST_CW3});
    do_reset();
    repeat (12) @(negedge clk);
    check_eq("mid_rst_cw_cnt", cw_cnt + ccw_cnt + err_cnt, 32'd0);
    check_eq("mid_rst_state", {29'd0, dut.state_q}, {29'd0, ST_REST});
    check_eq("mid_rst_outs", {29'd0, cw, ccw, seq_err}, 32'd0);

    check_eq("exclusive_outputs", excl_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
